// File: rtl/scoreboard_issue_pkg.sv
// Shared definitions for the scoreboard issue stage.
// Holds the producer-tag sizing rule, the "value is in the register file"
// tag, the default geometry and the functional-unit index names.
package scoreboard_issue_pkg;

    localparam int NUM_FU_DEF = 3;
    localparam int NREG_DEF   = 32;

    // Tag 0 means the operand is already in the register file.
    // Tag k means FU k-1 will produce it.
    localparam int TAG_RF = 0;

    typedef enum int {
        FU_ALU = 0,
        FU_MUL = 1,
        FU_LSU = 2
    } fu_id_e;

    // One encoding per FU, plus the register-file tag.
    function automatic int tag_width(input int num_fu);
        return $clog2(num_fu + 1);
    endfunction

endpackage

// File: rtl/scoreboard_issue_if.sv
// Issue and write-back bundle between the decode stage, the scoreboard
// and the functional units.
//   master : decode/FU side (drives the issue request and write-backs)
//   slave  : scoreboard side (drives ready, operand tags, load strobes, status)
interface scoreboard_issue_if
    import scoreboard_issue_pkg::*;
#(
    parameter int NUM_FU = NUM_FU_DEF,
    parameter int NREG   = NREG_DEF
) ();
    localparam int TAG_W = tag_width(NUM_FU);
    localparam int RW    = $clog2(NREG);

    logic                 iss_valid;
    logic                 iss_ready;
    logic [TAG_W-1:0]     iss_fu;
    logic [RW-1:0]        iss_rs1;
    logic [RW-1:0]        iss_rs2;
    logic [RW-1:0]        iss_rd;
    logic                 iss_wr_rd;
    logic [TAG_W-1:0]     src1_tag;
    logic [TAG_W-1:0]     src2_tag;
    logic [NUM_FU-1:0]    fu_load;
    logic [NUM_FU-1:0]    fu_busy;
    logic [NUM_FU-1:0]    wb_valid;
    logic [NUM_FU*RW-1:0] wb_rd;
    logic [TAG_W-1:0]     outstanding;
    logic                 wb_err;

    modport master (
        output iss_valid, iss_fu, iss_rs1, iss_rs2, iss_rd, iss_wr_rd,
        output wb_valid, wb_rd,
        input  iss_ready, src1_tag, src2_tag, fu_load, fu_busy,
        input  outstanding, wb_err
    );

    modport slave (
        input  iss_valid, iss_fu, iss_rs1, iss_rs2, iss_rd, iss_wr_rd,
        input  wb_valid, wb_rd,
        output iss_ready, src1_tag, src2_tag, fu_load, fu_busy,
        output outstanding, wb_err
    );

endinterface

// File: rtl/sb_clear_match.sv
// Flags that a register's pending tag is being released this cycle:
// some busy FU is writing back and its recorded destination is reg_idx.
//   wb_valid : per-FU write-back strobes
//   busy     : per-FU busy flags
//   rd_flat  : per-FU recorded destination, FU k in slice k
//   reg_idx  : register being looked up
//   hit      : release of reg_idx happens this cycle
module sb_clear_match #(
    parameter int NUM_FU = 3,
    parameter int RW     = 5
) (
    input  logic [NUM_FU-1:0]    wb_valid,
    input  logic [NUM_FU-1:0]    busy,
    input  logic [NUM_FU*RW-1:0] rd_flat,
    input  logic [RW-1:0]        reg_idx,
    output logic                 hit
);
    always_comb begin
        hit = 1'b0;
        for (int k = 0; k < NUM_FU; k++) begin
            if (wb_valid[k] && busy[k] && rd_flat[k*RW +: RW] == reg_idx) begin
                hit = 1'b1;
            end
        end
    end

endmodule

// File: rtl/scoreboard_issue.sv
// In-order issue scoreboard. Tracks which FU will produce each architectural
// register, stalls structural (FU busy) and WAW hazards, and reports producer
// tags for the source operands of the presented instruction.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : issue request/response, FU load strobes, write-backs, status
module scoreboard_issue
    import scoreboard_issue_pkg::*;
#(
    parameter int NUM_FU = NUM_FU_DEF,
    parameter int NREG   = NREG_DEF
) (
    input  logic              clk,
    input  logic              rst,
    scoreboard_issue_if.slave bus
);
    localparam int TAG_W = tag_width(NUM_FU);
    localparam int RW    = $clog2(NREG);

    logic [TAG_W-1:0]     tag_q [NREG];
    logic [NUM_FU-1:0]    busy_q;
    logic [NUM_FU*RW-1:0] rd_q;
    logic                 wb_err_q;

    logic                 clear_rs1;
    logic                 clear_rs2;
    logic                 clear_rd;
    logic [NUM_FU-1:0]    fu_sel;
    logic                 fu_free;
    logic                 waw;
    logic                 ready;
    logic                 accept;
    logic [TAG_W-1:0]     busy_cnt;

    // Release is keyed off the destination captured at issue, so the
    // write-back index bus carries no extra information here.
    logic                 wb_rd_unused;
    assign wb_rd_unused = ^bus.wb_rd;

    sb_clear_match #(.NUM_FU(NUM_FU), .RW(RW)) u_clr_rs1 (
        .wb_valid (bus.wb_valid),
        .busy     (busy_q),
        .rd_flat  (rd_q),
        .reg_idx  (bus.iss_rs1),
        .hit      (clear_rs1)
    );

    sb_clear_match #(.NUM_FU(NUM_FU), .RW(RW)) u_clr_rs2 (
        .wb_valid (bus.wb_valid),
        .busy     (busy_q),
        .rd_flat  (rd_q),
        .reg_idx  (bus.iss_rs2),
        .hit      (clear_rs2)
    );

    sb_clear_match #(.NUM_FU(NUM_FU), .RW(RW)) u_clr_rd (
        .wb_valid (bus.wb_valid),
        .busy     (busy_q),
        .rd_flat  (rd_q),
        .reg_idx  (bus.iss_rd),
        .hit      (clear_rd)
    );

    // One-hot FU select; an out-of-range index selects nothing and never issues.
    always_comb begin
        fu_sel = '0;
        for (int k = 0; k < NUM_FU; k++) begin
            fu_sel[k] = (bus.iss_fu == TAG_W'(k));
        end
    end

    // A busy FU finishing this cycle can take the next instruction, and a
    // pending destination being released this cycle is not a WAW hazard.
    always_comb begin
        fu_free = |(fu_sel & (~busy_q | bus.wb_valid));
        waw     = bus.iss_wr_rd && (bus.iss_rd != '0) &&
                  (tag_q[bus.iss_rd] != TAG_W'(TAG_RF)) && !clear_rd;
        ready   = fu_free && !waw;
        accept  = bus.iss_valid && ready;
    end

    always_comb begin
        busy_cnt = '0;
        for (int k = 0; k < NUM_FU; k++) begin
            busy_cnt = busy_cnt + TAG_W'(busy_q[k]);
        end
    end

    // Register file is write-through: an operand released this cycle reads as ready.
    assign bus.src1_tag    = (bus.iss_rs1 == '0 || clear_rs1) ? TAG_W'(TAG_RF) : tag_q[bus.iss_rs1];
    assign bus.src2_tag    = (bus.iss_rs2 == '0 || clear_rs2) ? TAG_W'(TAG_RF) : tag_q[bus.iss_rs2];
    assign bus.iss_ready   = ready;
    assign bus.fu_load     = accept ? fu_sel : '0;
    assign bus.fu_busy     = busy_q;
    assign bus.outstanding = busy_cnt;
    assign bus.wb_err      = wb_err_q;

    // Write-back updates come first so a same-cycle issue overrides them
    // (busy/rd of the reused FU, tag of the re-targeted register).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int r = 0; r < NREG; r++) begin
                tag_q[r] <= '0;
            end
            busy_q   <= '0;
            rd_q     <= '0;
            wb_err_q <= 1'b0;
        end else begin
            for (int k = 0; k < NUM_FU; k++) begin
                if (bus.wb_valid[k]) begin
                    if (busy_q[k]) begin
                        busy_q[k] <= 1'b0;
                        // Only release if no younger producer has claimed the register.
                        if (tag_q[rd_q[k*RW +: RW]] == TAG_W'(k + 1)) begin
                            tag_q[rd_q[k*RW +: RW]] <= TAG_W'(TAG_RF);
                        end
                    end else begin
                        wb_err_q <= 1'b1;
                    end
                end
            end
            if (accept) begin
                for (int k = 0; k < NUM_FU; k++) begin
                    if (fu_sel[k]) begin
                        busy_q[k]         <= 1'b1;
                        rd_q[k*RW +: RW]  <= bus.iss_rd;
                    end
                end
                if (bus.iss_wr_rd && bus.iss_rd != '0) begin
                    tag_q[bus.iss_rd] <= bus.iss_fu + TAG_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_scoreboard_issue.sv
module tb_scoreboard_issue;
    import scoreboard_issue_pkg::*;

    logic clk;
    logic rst;

    scoreboard_issue_if #(.NUM_FU(3), .NREG(32)) bus ();

    scoreboard_issue #(.NUM_FU(3), .NREG(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string    name;
        int       load;
        int       s1;
        int       s2;
    } exp_t;

    exp_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Monitor: every accepted issue must match the oldest expectation.
    always @(negedge clk) begin
        if (bus.fu_load != '0) begin
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_issue: got fu_load %0d expected no issue", bus.fu_load);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk({e.name, "_load"}, int'(bus.fu_load), e.load);
                chk({e.name, "_src1"}, int'(bus.src1_tag), e.s1);
                chk({e.name, "_src2"}, int'(bus.src2_tag), e.s2);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int v, input int fu, input int rs1, input int rs2,
                         input int rd, input int wr, input int wb);
        bus.iss_valid = v[0];
        bus.iss_fu    = fu[1:0];
        bus.iss_rs1   = rs1[4:0];
        bus.iss_rs2   = rs2[4:0];
        bus.iss_rd    = rd[4:0];
        bus.iss_wr_rd = wr[0];
        bus.wb_valid  = wb[2:0];
        bus.wb_rd     = '0;
    endtask

    task automatic expect_issue(input string name, input int load, input int s1, input int s2);
        exp_t e;
        e.name = name;
        e.load = load;
        e.s1   = s1;
        e.s2   = s2;
        exp_q.push_back(e);
    endtask

    initial begin
        rst = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0);
        @(posedge clk);
        #3;
        chk("rst_ready", int'(bus.iss_ready), 1);
        chk("rst_src1", int'(bus.src1_tag), 0);
        chk("rst_src2", int'(bus.src2_tag), 0);
        chk("rst_load", int'(bus.fu_load), 0);
        chk("rst_busy", int'(bus.fu_busy), 0);
        chk("rst_outst", int'(bus.outstanding), 0);
        chk("rst_wberr", int'(bus.wb_err), 0);
        step();
        rst = 1'b0;
        step();

        // ALU writes x5, then MUL reads x5.
        drive(1, FU_ALU, 1, 2, 5, 1, 0);
        expect_issue("alu_x5", 1, 0, 0);
        #2 chk("alu_x5_ready", int'(bus.iss_ready), 1);
        step();
        drive(1, FU_MUL, 5, 0, 6, 1, 0);
        expect_issue("mul_rd_x5", 2, 1, 0);
        #2 chk("mul_rd_x5_ready", int'(bus.iss_ready), 1);
        chk("outst_1", int'(bus.outstanding), 1);
        step();
        // ALU writes back x5; bypass makes x5 ready this cycle.
        drive(0, FU_LSU, 5, 6, 0, 0, 1);
        #2 chk("bypass_x5", int'(bus.src1_tag), 0);
        chk("pend_x6", int'(bus.src2_tag), 2);
        chk("outst_2", int'(bus.outstanding), 2);
        step();
        drive(1, FU_ALU, 5, 6, 8, 1, 0);
        expect_issue("alu_x8", 1, 0, 2);
        #2 chk("x5_clear_outst", int'(bus.outstanding), 1);
        step();

        // Structural stall on busy ALU, released by same-cycle write-back.
        drive(1, FU_ALU, 8, 0, 9, 1, 0);
        #2 chk("alu_busy_stall", int'(bus.iss_ready), 0);
        chk("stall_no_load", int'(bus.fu_load), 0);
        step();
        drive(1, FU_ALU, 8, 0, 9, 1, 1);
        expect_issue("alu_wb_reissue", 1, 0, 0);
        #2 chk("alu_wb_ready", int'(bus.iss_ready), 1);
        step();
        drive(0, FU_ALU, 8, 9, 0, 0, 0);
        #2 chk("alu_still_busy", int'(bus.fu_busy), 3);
        chk("x8_released", int'(bus.src1_tag), 0);
        chk("x9_pending", int'(bus.src2_tag), 1);
        step();
        drive(0, FU_ALU, 0, 0, 0, 0, 3);
        step();
        drive(0, FU_ALU, 6, 9, 0, 0, 0);
        #2 chk("dual_wb_outst", int'(bus.outstanding), 0);
        chk("x6_clear", int'(bus.src1_tag), 0);
        chk("x9_clear", int'(bus.src2_tag), 0);
        step();

        // WAW: MUL owns x7, LSU wants to write x7.
        drive(1, FU_MUL, 6, 9, 7, 1, 0);
        expect_issue("mul_x7", 2, 0, 0);
        step();
        drive(1, FU_LSU, 7, 0, 7, 1, 0);
        #2 chk("waw_stall", int'(bus.iss_ready), 0);
        chk("waw_src1", int'(bus.src1_tag), 2);
        step();
        #2 chk("waw_stall2", int'(bus.iss_ready), 0);
        step();
        drive(1, FU_LSU, 7, 0, 7, 1, 2);
        expect_issue("lsu_x7", 4, 0, 0);
        #2 chk("waw_release", int'(bus.iss_ready), 1);
        step();

        // x7 now owned by LSU; ALU claims x3, then MUL claims x4 while LSU retires.
        drive(1, FU_ALU, 7, 0, 3, 1, 0);
        expect_issue("alu_x3", 1, 3, 0);
        step();
        drive(1, FU_MUL, 3, 0, 4, 1, 4);
        expect_issue("mul_x4", 2, 1, 0);
        step();
        drive(0, FU_ALU, 3, 4, 0, 0, 3);
        #2 chk("pre_dual_outst", int'(bus.outstanding), 2);
        step();
        drive(0, FU_ALU, 3, 4, 0, 0, 0);
        #2 chk("post_dual_outst", int'(bus.outstanding), 0);
        chk("x3_clear", int'(bus.src1_tag), 0);
        chk("x4_clear", int'(bus.src2_tag), 0);
        bus.iss_rs1 = 5'd7;
        #1 chk("x7_clear", int'(bus.src1_tag), 0);
        step();

        // Register 0 never gets a tag; stray write-back sets sticky error.
        drive(1, FU_ALU, 0, 0, 0, 1, 0);
        expect_issue("alu_x0", 1, 0, 0);
        step();
        drive(1, FU_MUL, 0, 0, 0, 1, 0);
        expect_issue("mul_x0", 2, 0, 0);
        #2 chk("x0_no_waw", int'(bus.iss_ready), 1);
        step();
        drive(0, FU_ALU, 0, 0, 0, 0, 4);
        #2 chk("wberr_before", int'(bus.wb_err), 0);
        step();
        drive(0, FU_ALU, 0, 0, 0, 0, 0);
        #2 chk("wberr_set", int'(bus.wb_err), 1);
        chk("wberr_busy_kept", int'(bus.fu_busy), 3);
        step();
        drive(1, FU_LSU, 0, 0, 10, 1, 0);
        expect_issue("lsu_x10", 4, 0, 0);
        #2 chk("wberr_held", int'(bus.wb_err), 1);
        step();

        // Asynchronous reset with all three FUs busy.
        drive(0, FU_ALU, 10, 0, 0, 0, 0);
        #2 chk("all_busy_outst", int'(bus.outstanding), 3);
        chk("x10_pending", int'(bus.src1_tag), 3);
        rst = 1'b1;
        #1 chk("async_outst", int'(bus.outstanding), 0);
        chk("async_busy", int'(bus.fu_busy), 0);
        chk("async_wberr", int'(bus.wb_err), 0);
        chk("async_src1", int'(bus.src1_tag), 0);
        chk("async_ready", int'(bus.iss_ready), 1);
        step();
        rst = 1'b0;
        drive(0, FU_ALU, 0, 0, 0, 0, 1);
        step();
        drive(0, FU_ALU, 10, 0, 0, 0, 0);
        #2 chk("post_rst_wberr", int'(bus.wb_err), 1);
        chk("post_rst_x10", int'(bus.src1_tag), 0);
        step();
        step();

        chk("issues_left", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
